// File: rtl/lsu_axi_master.sv
// Memory-stage load/store unit: one packet in, one AXI4-Lite read or write out, one result to W.
// Optional build macro LSU_MISALIGN_CHECK_EN faults misaligned half/word accesses without bus traffic.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | s_ready high, waiting for a packet from the M-stage register
// S_RD_ADDR | arvalid high, waiting for arready
// S_RD_DATA | rready high, waiting for rvalid
// S_WR_REQ  | AW and/or W still outstanding, each retired independently
// S_WR_RESP | bready high, waiting for bvalid
// S_DONE    | m_valid high, result held until m_ready
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              mvalid,
  input  logic              mwen,
  input  logic [7:0]        mwmask,
  input  logic [2:0]        mrtype,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [4:0]        rd_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] ldata,
  output logic [4:0]        rd_out,
  output logic              fault,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, ldata_q, ldata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              fault_q, fault_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        mrtype_q, mrtype_d;

  logic              misalign;
  logic              aw_done, w_done;
  logic [DATA_W-1:0] lane;
  logic              unused_mwmask_hi;

  assign unused_mwmask_hi = ^mwmask[7:4];

`ifdef LSU_MISALIGN_CHECK_EN
  logic is_half, is_word;
  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    if (mwen) begin
      is_half = (mwmask[3:0] == 4'h3);
      is_word = (mwmask[3:0] == 4'hF);
    end else begin
      is_half = (mrtype[1:0] == 2'b01);
      is_word = (mrtype[1:0] != 2'b00) && (mrtype[1:0] != 2'b01);
    end
    misalign = mvalid && ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));
  end
`else
  assign misalign = 1'b0;
`endif

  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q  || wready;
  assign lane    = rdata >> {off_q, 3'b000};

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ldata_d   = ldata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    rd_out_d  = rd_out_q;
    fault_d   = fault_q;
    off_d     = off_q;
    mrtype_d  = mrtype_q;
    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          off_d    = addr[1:0];
          mrtype_d = mrtype;
          rd_out_d = rd_in;
          fault_d  = 1'b0;
          ldata_d  = '0;
          if (!mvalid) begin
            state_d = S_DONE;
          end else if (misalign) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else if (!mwen) begin
            araddr_d  = {addr[ADDR_W-1:2], 2'b00};
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end else begin
            awaddr_d  = {addr[ADDR_W-1:2], 2'b00};
            wstrb_d   = mwmask[3:0] << addr[1:0];
            wdata_d   = wdata_in << {addr[1:0], 3'b000};
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end
        end
      end
      S_RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (rvalid) begin
          case (mrtype_q)
            3'b000:  ldata_d = {{(DATA_W-8){lane[7]}}, lane[7:0]};
            3'b001:  ldata_d = {{(DATA_W-16){lane[15]}}, lane[15:0]};
            3'b100:  ldata_d = {{(DATA_W-8){1'b0}}, lane[7:0]};
            3'b101:  ldata_d = {{(DATA_W-16){1'b0}}, lane[15:0]};
            default: ldata_d = lane;
          endcase
          fault_d  = (rresp != 2'b00);
          rready_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_WR_REQ: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (bvalid) begin
          fault_d  = (bresp != 2'b00);
          bready_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (m_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ldata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      rd_out_q  <= '0;
      fault_q   <= 1'b0;
      off_q     <= '0;
      mrtype_q  <= '0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ldata_q   <= ldata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      rd_out_q  <= rd_out_d;
      fault_q   <= fault_d;
      off_q     <= off_d;
      mrtype_q  <= mrtype_d;
    end
  end

  assign s_ready = (state_q == S_IDLE);
  assign m_valid = (state_q == S_DONE);
  assign ldata   = ldata_q;
  assign rd_out  = rd_out_q;
  assign fault   = fault_q;
  assign araddr  = araddr_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awaddr  = awaddr_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Scoreboard bench for lsu_axi_master: expected W-stage results are queued at accept
// and popped when m_valid appears; AXI slave responses are driven from each scenario task.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready, mvalid, mwen;
  logic [7:0]  mwmask;
  logic [2:0]  mrtype;
  logic [31:0] addr, wdata_in;
  logic [4:0]  rd_in, rd_out;
  logic        m_valid, m_ready, fault;
  logic [31:0] ldata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  typedef struct packed {
    logic [31:0] ld;
    logic [4:0]  rd;
    logic        flt;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  lsu_axi_master dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .mvalid(mvalid), .mwen(mwen), .mwmask(mwmask), .mrtype(mrtype),
    .addr(addr), .wdata_in(wdata_in), .rd_in(rd_in),
    .m_valid(m_valid), .m_ready(m_ready), .ldata(ldata), .rd_out(rd_out), .fault(fault),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  function automatic logic [31:0] model_load(input logic [31:0] rd_word, input int off,
                                             input logic [2:0] mt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    w = rd_word;
    b = w[off*8 +: 8];
    h = (off <= 2) ? w[off*8 +: 16] : {8'h00, w[31:24]};
    case (mt)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w >> (off * 8);
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({s_ready, m_valid, arvalid, rready, awvalid, wvalid, bready} !== 7'b1000000) begin
      nmis++;
      $display("FAIL reset_ctl: got %b want 1000000", {s_ready, m_valid, arvalid, rready, awvalid, wvalid, bready});
    end
    nvec++;
    if ({ldata, rd_out, fault, araddr, awaddr, wdata, wstrb} !== '0) begin
      nmis++;
      $display("FAIL reset_data: ldata=%h rd_out=%0d fault=%b araddr=%h awaddr=%h wdata=%h wstrb=%h want all zero",
               ldata, rd_out, fault, araddr, awaddr, wdata, wstrb);
    end
  endtask

  task automatic test_nonmem(input logic [4:0] rd);
    exp_t e, got;
    exp_q.push_back('{ld: 32'h0, rd: rd, flt: 1'b0});
    @(negedge clk);
    s_valid = 1'b1; mvalid = 1'b0; mwen = 1'b0; rd_in = rd; addr = 32'h1234_5677;
    @(negedge clk);
    s_valid = 1'b0;
    nvec++;
    if ({m_valid, arvalid, awvalid} !== 3'b100) begin
      nmis++;
      $display("FAIL nonmem_latency: m_valid/arvalid/awvalid got %b want 100", {m_valid, arvalid, awvalid});
    end
    if (m_valid === 1'b1) begin
      got = '{ld: ldata, rd: rd_out, flt: fault};
      e = exp_q.pop_front();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL nonmem_result: got ld=%h rd=%0d f=%b want ld=%h rd=%0d f=%b", got.ld, got.rd, got.flt, e.ld, e.rd, e.flt);
      end
    end
    @(negedge clk);
    nvec++;
    if ({m_valid, s_ready} !== 2'b01) begin
      nmis++;
      $display("FAIL nonmem_return: m_valid/s_ready got %b want 01", {m_valid, s_ready});
    end
  endtask

  task automatic test_load(input string nm, input logic [31:0] a, input logic [2:0] mt,
                           input logic [31:0] rword, input logic [1:0] rr,
                           input logic [31:0] exp_ld, input logic [4:0] rd, input int hold);
    exp_t e, got;
    exp_q.push_back('{ld: exp_ld, rd: rd, flt: (rr != 2'b00)});
    @(negedge clk);
    nvec++;
    if (s_ready !== 1'b1) begin
      nmis++;
      $display("FAIL %s_sready: got %b want 1", nm, s_ready);
    end
    s_valid = 1'b1; mvalid = 1'b1; mwen = 1'b0; mrtype = mt; addr = a; rd_in = rd;
    @(negedge clk);
    s_valid = 1'b0;
    nvec++;
    if ({arvalid, awvalid, araddr} !== {2'b10, a[31:2], 2'b00}) begin
      nmis++;
      $display("FAIL %s_ar: arvalid=%b awvalid=%b araddr=%h want 1 0 %h", nm, arvalid, awvalid, araddr, {a[31:2], 2'b00});
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    nvec++;
    if ({arvalid, rready} !== 2'b01) begin
      nmis++;
      $display("FAIL %s_rready: arvalid/rready got %b want 01", nm, {arvalid, rready});
    end
    rvalid = 1'b1; rdata = rword; rresp = rr;
    if (hold > 0) m_ready = 1'b0;
    @(negedge clk);
    rvalid = 1'b0; rdata = 32'hDEAD_DEAD; rresp = 2'b11;
    nvec++;
    if ({m_valid, rready} !== 2'b10) begin
      nmis++;
      $display("FAIL %s_done: m_valid/rready got %b want 10", nm, {m_valid, rready});
    end
    if (m_valid === 1'b1) begin
      got = '{ld: ldata, rd: rd_out, flt: fault};
      e = exp_q.pop_front();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL %s_result: got ld=%h rd=%0d f=%b want ld=%h rd=%0d f=%b", nm, got.ld, got.rd, got.flt, e.ld, e.rd, e.flt);
      end
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        nvec++;
        if ({m_valid, s_ready, ldata, rd_out, fault} !== {2'b10, e.ld, e.rd, e.flt}) begin
          nmis++;
          $display("FAIL %s_hold%0d: m_valid=%b s_ready=%b ld=%h rd=%0d f=%b want 1 0 %h %0d %b",
                   nm, h, m_valid, s_ready, ldata, rd_out, fault, e.ld, e.rd, e.flt);
        end
        if (h == hold - 1) m_ready = 1'b1;
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if ({m_valid, s_ready} !== 2'b01) begin
      nmis++;
      $display("FAIL %s_release: m_valid/s_ready got %b want 01", nm, {m_valid, s_ready});
    end
  endtask

  task automatic test_store(input string nm, input logic [31:0] a, input logic [31:0] wd,
                            input logic [7:0] mask, input int aw_dly, input int w_dly,
                            input logic [1:0] br, input logic [31:0] exp_wd,
                            input logic [3:0] exp_st, input logic [4:0] rd);
    exp_t e, got;
    int   last;
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    exp_q.push_back('{ld: 32'h0, rd: rd, flt: (br != 2'b00)});
    @(negedge clk);
    s_valid = 1'b1; mvalid = 1'b1; mwen = 1'b1; mwmask = mask; addr = a; wdata_in = wd; rd_in = rd;
    @(negedge clk);
    s_valid = 1'b0;
    nvec++;
    if ({arvalid, awaddr, wstrb, wdata} !== {1'b0, a[31:2], 2'b00, exp_st, exp_wd}) begin
      nmis++;
      $display("FAIL %s_req: arvalid=%b awaddr=%h wstrb=%h wdata=%h want 0 %h %h %h",
               nm, arvalid, awaddr, wstrb, wdata, {a[31:2], 2'b00}, exp_st, exp_wd);
    end
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(negedge clk);
      nvec++;
      if ({awvalid, wvalid, bready} !== {(k <= aw_dly), (k <= w_dly), 1'b0}) begin
        nmis++;
        $display("FAIL %s_valids_c%0d: awvalid/wvalid/bready got %b want %b%b0",
                 nm, k, {awvalid, wvalid, bready}, (k <= aw_dly), (k <= w_dly));
      end
      awready = (k == aw_dly);
      wready  = (k == w_dly);
    end
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    nvec++;
    if ({awvalid, wvalid, bready, m_valid} !== 4'b0010) begin
      nmis++;
      $display("FAIL %s_bready: awvalid/wvalid/bready/m_valid got %b want 0010", nm, {awvalid, wvalid, bready, m_valid});
    end
    bvalid = 1'b1; bresp = br;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    nvec++;
    if ({m_valid, bready} !== 2'b10) begin
      nmis++;
      $display("FAIL %s_done: m_valid/bready got %b want 10", nm, {m_valid, bready});
    end
    if (m_valid === 1'b1) begin
      got = '{ld: ldata, rd: rd_out, flt: fault};
      e = exp_q.pop_front();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL %s_result: got ld=%h rd=%0d f=%b want ld=%h rd=%0d f=%b", nm, got.ld, got.rd, got.flt, e.ld, e.rd, e.flt);
      end
    end
    @(negedge clk);
    nvec++;
    if ({m_valid, s_ready} !== 2'b01) begin
      nmis++;
      $display("FAIL %s_single: m_valid/s_ready got %b want 01", nm, {m_valid, s_ready});
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    s_valid = 1'b1; mvalid = 1'b1; mwen = 1'b0; mrtype = 3'b010; addr = 32'h8000_0040; rd_in = 5'd9;
    @(negedge clk);
    s_valid = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    nvec++;
    if (rready !== 1'b1) begin
      nmis++;
      $display("FAIL rstmid_inread: rready got %b want 1", rready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nvec++;
    if ({s_ready, rready, m_valid, arvalid} !== 4'b1000) begin
      nmis++;
      $display("FAIL rstmid_idle: s_ready/rready/m_valid/arvalid got %b want 1000", {s_ready, rready, m_valid, arvalid});
    end
    rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    @(negedge clk);
    nvec++;
    if ({m_valid, s_ready, ldata, rd_out} !== {2'b01, 32'h0, 5'd0}) begin
      nmis++;
      $display("FAIL rstmid_late_rvalid: m_valid=%b s_ready=%b ldata=%h rd_out=%0d want 0 1 0 0",
               m_valid, s_ready, ldata, rd_out);
    end
  endtask

  task automatic test_misalign();
    exp_t e, got;
    exp_q.push_back('{ld: 32'h0, rd: 5'd12, flt: 1'b1});
    @(negedge clk);
    s_valid = 1'b1; mvalid = 1'b1; mwen = 1'b0; mrtype = 3'b010; addr = 32'h8000_0002; rd_in = 5'd12;
    @(negedge clk);
    s_valid = 1'b0;
    nvec++;
    if ({m_valid, arvalid, awvalid, wvalid} !== 4'b1000) begin
      nmis++;
      $display("FAIL misalign_lw: m_valid/arvalid/awvalid/wvalid got %b want 1000", {m_valid, arvalid, awvalid, wvalid});
    end
    if (m_valid === 1'b1) begin
      got = '{ld: ldata, rd: rd_out, flt: fault};
      e = exp_q.pop_front();
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL misalign_result: got ld=%h rd=%0d f=%b want ld=%h rd=%0d f=%b", got.ld, got.rd, got.flt, e.ld, e.rd, e.flt);
      end
    end
    @(negedge clk);
    nvec++;
    if ({m_valid, s_ready, arvalid} !== 3'b010) begin
      nmis++;
      $display("FAIL misalign_return: m_valid/s_ready/arvalid got %b want 010", {m_valid, s_ready, arvalid});
    end
  endtask

  task automatic test_random_loads();
    logic [2:0]  types[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  mt;
    logic [31:0] rw, a;
    int          off;
    for (int i = 0; i < 8; i++) begin
      mt  = types[$urandom_range(0, 4)];
      rw  = $urandom;
      off = (mt[1:0] == 2'b00) ? $urandom_range(0, 3) : (mt[1:0] == 2'b01) ? 2 * $urandom_range(0, 1) : 0;
      a   = {$urandom_range(0, 255), 8'h00} | off;
      test_load("rand_ld", a, mt, rw, 2'b00, model_load(rw, off, mt), 5'(i + 1), 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; mvalid = 1'b0; mwen = 1'b0; mwmask = 8'h00; mrtype = 3'b000;
    addr = '0; wdata_in = '0; rd_in = '0; m_ready = 1'b1;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;

    test_reset();
    test_nonmem(5'd5);
    test_load("lb",  32'h8000_0003, 3'b000, 32'h80FF_1234, 2'b00, 32'hFFFF_FF80, 5'd3, 0);
    test_load("lbu", 32'h8000_0003, 3'b100, 32'h80FF_1234, 2'b00, 32'h0000_0080, 5'd4, 0);
    test_load("lh",  32'h8000_0002, 3'b001, 32'h80FF_1234, 2'b00, 32'hFFFF_80FF, 5'd6, 0);
    test_load("lhu", 32'h8000_0002, 3'b101, 32'h80FF_1234, 2'b00, 32'h0000_80FF, 5'd7, 0);
    test_load("lh0", 32'h8000_0000, 3'b001, 32'h80FF_1234, 2'b00, 32'h0000_1234, 5'd8, 0);
    test_load("lwundef", 32'h8000_0010, 3'b011, 32'h8765_4321, 2'b00, 32'h8765_4321, 5'd10, 0);
    test_load("lw_err", 32'h8000_0020, 3'b010, 32'h1234_5678, 2'b10, 32'h1234_5678, 5'd11, 3);
    test_store("sh", 32'h8000_0002, 32'h0000_ABCD, 8'h03, 0, 2, 2'b00, 32'hABCD_0000, 4'hC, 5'd13);
    test_store("sw", 32'h8000_0010, 32'h1122_3344, 8'hFF, 0, 0, 2'b00, 32'h1122_3344, 4'hF, 5'd14);
    test_store("sb", 32'h8000_0005, 32'h0000_005A, 8'h01, 3, 1, 2'b11, 32'h0000_5A00, 4'h2, 5'd15);
    test_reset_mid_read();
    test_nonmem(5'd31);
`ifdef LSU_MISALIGN_CHECK_EN
    test_misalign();
`else
    test_load("lw_mis", 32'h8000_0002, 3'b010, 32'hDEAD_BEEF, 2'b00, 32'h0000_DEAD, 5'd12, 0);
`endif
    test_random_loads();

    nvec++;
    if (exp_q.size() !== 0) begin
      nmis++;
      $display("FAIL scoreboard_drain: %0d results outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- Memory-stage load/store unit. It is the consuming end of the X->M stage register's `m_valid`/`m_ready` handshake.
- Accepts one memory-stage packet at a time and issues one AXI4-Lite read or write on the data bus.
- Aligns load data and sign- or zero-extends it per `mrtype`.
- Presents the result to the writeback stage through a valid/ready handshake.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Fixed at 32; other values unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  packet valid from M-stage register
- s_ready  out  1  LSU can accept a packet
- mvalid  in  1  packet is a memory access
- mwen  in  1  1=store, 0=load (qualified by mvalid)
- mwmask  in  8  store byte mask, LSB-aligned (0x01/0x03/0x0F); bits [7:4] ignored
- mrtype  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- addr  in  32  effective address (ALU result)
- wdata_in  in  32  store data, LSB-aligned (src2)
- rd_in  in  5  destination register, passed through
- m_valid  out  1  result valid to W stage
- m_ready  in  1  W stage accepts
- ldata  out  32  extended load data (0 for stores and non-memory packets)
- rd_out  out  5  registered rd_in
- fault  out  1  access fault for this packet
- araddr/arvalid/arready, rdata/rresp/rvalid/rready: AXI4-Lite read channels, 32/1/1, 32/2/1/1
- awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready: AXI4-Lite write channels, 32/1/1, 32/4/1/1, 2/1/1

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- `s_ready` = (state==IDLE). `m_valid` = (state==DONE).
- Reset:
  - state=IDLE; all AXI valids/readies=0.
  - `ldata`=0, `rd_out`=0, `fault`=0.
  - `araddr`/`awaddr`/`wdata`/`wstrb`=0.
- Reset mid-transaction: abandon the transaction immediately and return to IDLE; no completion is produced.
- On `s_valid & s_ready`:
  - Latch all inputs.
  - `rd_out` <= `rd_in`; `fault` <= 0.
  - Next state:
    - mvalid=0 -> DONE. Latency 1 cycle; `ldata`=0.
    - mvalid=1, mwen=0 -> RD_ADDR. `araddr` = `addr` with [1:0] cleared; `arvalid`=1.
    - mvalid=1, mwen=1 -> WR_REQ.
      - `awaddr` = word-aligned `addr`; `awvalid`=1; `wvalid`=1.
      - `wstrb` = `mwmask[3:0]` << `addr[1:0]`.
      - `wdata` = `wdata_in` << (8*`addr[1:0]`).
- RD_ADDR:
  - On `arready`: drop `arvalid`, raise `rready`, go to RD_DATA.
  - `arready` arriving in the same cycle `arvalid` rises is honoured.
- RD_DATA:
  - On `rvalid`:
    - Byte lane = `rdata` >> (8*`addr[1:0]`).
    - Extension per `mrtype`: lb sign-extends bit 7; lh sign-extends bit 15; lw uses the full word; lbu/lhu zero-extend.
    - Undefined `mrtype` behaves as lw.
    - `fault` <= (`rresp`!=0).
    - Drop `rready`, go to DONE.
- WR_REQ:
  - AW and W channels complete independently. Each valid drops the cycle after its own ready is seen; both may complete in the same cycle.
  - When both are done, raise `bready` and go to WR_RESP.
- WR_RESP:
  - On `bvalid`: `fault` <= (`bresp`!=0); drop `bready`; go to DONE.
- DONE:
  - Hold `ldata`/`rd_out`/`fault` stable while `m_ready`=0.
  - On `m_ready`, go to IDLE. The next packet is accepted no earlier than the following cycle; minimum initiation interval is 2 cycles.
- Exactly one outstanding AXI transaction. AXI valids never drop before their handshake, except on reset.

Optional Feature:
- LSU_MISALIGN_CHECK_EN.
- Defined: a memory packet is misaligned if lh/lhu/sh has `addr[0]`=1, or lw/sw has `addr[1:0]`!=0. Store size is taken from `mwmask`: 0x03=half, 0x0F=word.
  - A misaligned packet issues no AXI traffic.
  - It goes directly to DONE with `fault`=1 and `ldata`=0.
- Undefined: no alignment check.
  - Misaligned accesses are issued as-is with shifted strobes; out-of-word bytes are dropped.
  - `fault` reflects only bus response.

Test Plan:
- Non-memory packet, mvalid=0, rd_in=5, m_ready=1 -> `m_valid` one cycle after accept, `ldata`=0, `rd_out`=5, no arvalid/awvalid.
- lb at addr 0x8000_0003, slave rdata=0x80FF_1234, rresp=0 -> araddr=0x8000_0000, `ldata`=0xFFFF_FF80, `fault`=0. Repeat with lbu -> `ldata`=0x0000_0080.
- sh at addr 0x8000_0002, wdata_in=0x0000_ABCD, mwmask=0x03; awready 2 cycles before wready -> wstrb=0xC, wdata=0xABCD_0000, one completion after bvalid.
- lw with rresp=2'b10 and `m_ready` held low 3 cycles -> `fault`=1; `m_valid` and `ldata` stable for 3 cycles; `s_ready`=0 throughout.
- Assert rst while in RD_DATA -> next cycle state=IDLE, `rready`=0, `m_valid`=0, `s_ready`=1; a late `rvalid` is ignored.
- With LSU_MISALIGN_CHECK_EN defined, lw at addr 0x8000_0002 -> no arvalid, `fault`=1, `ldata`=0, `m_valid` one cycle after accept.
